// File: rtl/aardvark_pkg.sv
// Shared widths, ALU opcodes and sequencer state encoding for the 8-bit ALU datapath.
package aardvark_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int OP_W       = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: reads two operands through one register-file port, drives the
// external ALU, then writes back the result and updates the architectural zero flag.
module alu_sequencer
  import aardvark_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_W-1:0]       req_op,
  input  logic [REG_ADDR_W-1:0] req_rs,
  input  logic [REG_ADDR_W-1:0] req_rt,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic                  req_wb,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [OP_W-1:0]       alu_op,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  output logic                  done,
  output logic                  zero_flag
);

  seq_state_e            state;
  logic [OP_W-1:0]       op_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wb_q;
  logic [DATA_W-1:0]     a_q;
  logic                  zq;

  // Every output is registered: each state loads the values the next state presents,
  // so rs goes straight into rf_raddr and the B operand / result live in alu_b / rf_wdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      a_q       <= '0;
      zq        <= 1'b0;
      req_ready <= 1'b1;
      rf_raddr  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      done      <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            rt_q      <= req_rt;
            rd_q      <= req_rd;
            wb_q      <= req_wb;
            rf_raddr  <= req_rs;
            req_ready <= 1'b0;
            state     <= RD_A;
          end
        end
        // RD_A -> RD_B: capture operand A, point the read port at rt
        RD_A: begin
          a_q      <= rf_rdata;
          rf_raddr <= rt_q;
          state    <= RD_B;
        end
        // RD_B -> EXEC: operand B goes directly onto the ALU input
        RD_B: begin
          rf_raddr <= '0;
          alu_a    <= a_q;
          alu_b    <= rf_rdata;
          alu_op   <= op_q;
          state    <= EXEC;
        end
        // EXEC -> WB: capture result and zero, stage the write-back
        EXEC: begin
          alu_a    <= '0;
          alu_b    <= '0;
          alu_op   <= '0;
          zq       <= alu_zero;
          rf_we    <= wb_q;
          rf_waddr <= rd_q;
          rf_wdata <= alu_result;
          done     <= 1'b1;
          state    <= WB;
        end
        // WB -> IDLE: retire; the flag commits only here so an abort leaves it untouched
        WB: begin
          zero_flag <= zq;
          rf_we     <= 1'b0;
          rf_waddr  <= '0;
          rf_wdata  <= '0;
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: ALU and 8x8 register-file models plus a sequential reference model.
module tb_alu_sequencer;
  import aardvark_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready;
  logic [OP_W-1:0]       req_op;
  logic [REG_ADDR_W-1:0] req_rs, req_rt, req_rd;
  logic                  req_wb;
  logic [REG_ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0]     rf_rdata;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic [DATA_W-1:0]     alu_a, alu_b;
  logic [OP_W-1:0]       alu_op;
  logic [DATA_W-1:0]     alu_result;
  logic                  alu_zero;
  logic                  done;
  logic                  zero_flag;

  logic                  ld_en;
  logic [REG_ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0]     ld_data;

  logic [DATA_W-1:0] rf     [0:7];
  logic [DATA_W-1:0] ref_rf [0:7];
  logic              ref_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_wb(req_wb),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .done(done), .zero_flag(zero_flag)
  );

  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);
  assign rf_rdata   = rf[rf_raddr];

  always_ff @(posedge clk) begin
    if (rf_we)      rf[rf_waddr] <= rf_wdata;
    else if (ld_en) rf[ld_addr]  <= ld_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic preload(input logic [REG_ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    ref_rf[addr] = data;
  endtask

  task automatic chk_rf();
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), 32'(rf[i]), 32'(ref_rf[i]));
  endtask

  // One full instruction, entered and left at a negedge with the sequencer idle.
  task automatic run_instr(input logic [OP_W-1:0] op, input logic [REG_ADDR_W-1:0] rs,
                           input logic [REG_ADDR_W-1:0] rt, input logic [REG_ADDR_W-1:0] rd,
                           input logic wb, input bit junk);
    logic [DATA_W-1:0] ea, eb, er;
    ea = ref_rf[rs];
    eb = ref_rf[rt];
    er = alu_fn(op, ea, eb);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_wb = wb; req_valid = 1'b1;
    @(negedge clk);
    req_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    if (junk) begin
      req_op = 3'($urandom_range(0, 7)); req_rs = 3'($urandom_range(0, 7));
      req_rt = 3'($urandom_range(0, 7)); req_rd = 3'($urandom_range(0, 7));
      req_wb = 1'($urandom_range(0, 1));
    end
    chk("ready_rda", 32'(req_ready), 32'd0);
    chk("raddr_rs", 32'(rf_raddr), 32'(rs));
    @(negedge clk);
    chk("raddr_rt", 32'(rf_raddr), 32'(rt));
    @(negedge clk);
    chk("exec_a", 32'(alu_a), 32'(ea));
    chk("exec_b", 32'(alu_b), 32'(eb));
    chk("exec_op", 32'(alu_op), 32'(op));
    chk("exec_done", 32'(done), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_we", 32'(rf_we), 32'(wb));
    chk("wb_waddr", 32'(rf_waddr), 32'(rd));
    chk("wb_wdata", 32'(rf_wdata), 32'(er));
    if (wb) ref_rf[rd] = er;
    ref_z = (er == '0);
    @(negedge clk);
    chk("idle_zflag", 32'(zero_flag), 32'(ref_z));
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_we", 32'(rf_we), 32'd0);
  endtask

  initial begin
    int d1, d2;
    logic [DATA_W-1:0] ea, eb;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0;
    req_wb = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ref_z = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_zflag", 32'(zero_flag), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom_range(0, 255)));

    // Basic add
    preload(3'd1, 8'h01); preload(3'd2, 8'hFE);
    run_instr(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
    chk("t1_r3", 32'(rf[3]), 32'hFF);
    chk("t1_zflag", 32'(zero_flag), 32'd0);

    // Compare-only subtract sets the flag, which then holds
    preload(3'd4, 8'h05); preload(3'd5, 8'h05);
    run_instr(OP_SUB, 3'd4, 3'd5, 3'd7, 1'b0, 1'b0);
    chk("t2_zflag", 32'(zero_flag), 32'd1);
    repeat (3) @(negedge clk);
    chk("t2_zhold", 32'(zero_flag), 32'd1);
    chk_rf();

    // Back-to-back requests with req_valid held high
    req_op = OP_XOR; req_rs = 3'd1; req_rt = 3'd3; req_rd = 3'd0; req_wb = 1'b1;
    req_valid = 1'b1;
    d1 = -1; d2 = -1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin req_op = OP_ADD; req_rs = 3'd0; req_rt = 3'd2; req_rd = 3'd5; end
      if (c == 6) req_valid = 1'b0;
      if (c <= 4) chk("t3_ready_lo", 32'(req_ready), 32'd0);
      if (c == 5) chk("t3_ready_hi", 32'(req_ready), 32'd1);
      if (done && d1 < 0) d1 = c;
      else if (done && d2 < 0) d2 = c;
    end
    chk("t3_done1", 32'(d1), 32'd4);
    chk("t3_done2", 32'(d2), 32'd9);
    ref_rf[0] = ref_rf[1] ^ ref_rf[3];
    ref_rf[5] = ref_rf[0] + ref_rf[2];
    ref_z = (ref_rf[5] == '0);
    chk("t3_zflag", 32'(zero_flag), 32'(ref_z));
    chk_rf();

    // rs == rt == rd, result visible to the next read
    preload(3'd1, 8'h10);
    run_instr(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b1, 1'b0);
    chk("t4_r1a", 32'(rf[1]), 32'h20);
    run_instr(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b1, 1'b0);
    chk("t4_r1b", 32'(rf[1]), 32'h40);

    // Reset during EXEC aborts the instruction
    run_instr(OP_SUB, 3'd4, 3'd5, 3'd7, 1'b0, 1'b0);
    preload(3'd2, 8'h33); preload(3'd3, 8'h44);
    req_op = OP_ADD; req_rs = 3'd2; req_rt = 3'd3; req_rd = 3'd2; req_wb = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_z = 1'b0;
    chk("t5_we", 32'(rf_we), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_zflag", 32'(zero_flag), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_quiet_done", 32'(done), 32'd0);
      chk("t5_quiet_we", 32'(rf_we), 32'd0);
    end
    chk("t5_r2", 32'(rf[2]), 32'h33);
    chk_rf();

    // AND then OR on complementary nibbles
    preload(3'd1, 8'hF0); preload(3'd2, 8'h0F);
    run_instr(OP_AND, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0);
    chk("t6_and", 32'(rf[6]), 32'h00);
    chk("t6_zand", 32'(zero_flag), 32'd1);
    run_instr(OP_OR, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0);
    chk("t6_or", 32'(rf[6]), 32'hFF);
    chk("t6_zor", 32'(zero_flag), 32'd0);

    // Random instruction stream with junk on the request bus while busy
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) preload(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      ea = 8'($urandom_range(0, 7));
      eb = 8'($urandom_range(0, 7));
      run_instr(3'($urandom_range(0, 7)), 3'(ea), 3'(eb), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'b1);
    end
    chk_rf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
